// File: rtl/ecc_ctrl_pkg.sv
// Shared types for the left-to-right double-and-add scalar multiplication sequencer.
package ecc_ctrl_pkg;

    localparam int ECC_N = 231;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_DBL_REQ  = 3'd2,
        ST_DBL_WAIT = 3'd3,
        ST_ADD_REQ  = 3'd4,
        ST_ADD_WAIT = 3'd5,
        ST_NEXT     = 3'd6,
        ST_FIN      = 3'd7
    } ctrl_state_e;

    typedef struct packed {
        logic [ECC_N-1:0] x;
        logic [ECC_N-1:0] y;
        logic             inf;
    } ecc_point_t;

    localparam ecc_point_t INF_POINT = '{x: {ECC_N{1'b0}}, y: {ECC_N{1'b0}}, inf: 1'b1};

endpackage

// File: rtl/ecc_scalar_mult_ctrl.sv
// Double-and-add sequencer for R = k*P driving external doubling/addition units.
// ECC_DUMMY_ADD_EN: issue an addition for every bit after the leading one, committing only set bits.
module ecc_scalar_mult_ctrl
    import ecc_ctrl_pkg::*;
#(
    parameter int N  = ECC_N,
    parameter int KW = 231,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [N-1:0]  px,
    input  logic [N-1:0]  py,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  rx,
    output logic [N-1:0]  ry,
    output logic          r_inf,
    output logic          dbl_start,
    output logic [N-1:0]  dbl_x,
    output logic [N-1:0]  dbl_y,
    input  logic          dbl_done,
    input  logic [N-1:0]  dbl_x3,
    input  logic [N-1:0]  dbl_y3,
    input  logic          dbl_inf,
    output logic          add_start,
    output logic [N-1:0]  add_x1,
    output logic [N-1:0]  add_y1,
    output logic [N-1:0]  add_x2,
    output logic [N-1:0]  add_y2,
    input  logic          add_done,
    input  logic [N-1:0]  add_x3,
    input  logic [N-1:0]  add_y3,
    input  logic          add_inf
);

`ifdef ECC_DUMMY_ADD_EN
    localparam logic DUMMY_ADD = 1'b1;
`else
    localparam logic DUMMY_ADD = 1'b0;
`endif

    ctrl_state_e   state_r, state_s;
    ecc_point_t    acc_r;
    logic [KW-1:0] k_r;
    logic [N-1:0]  px_r, py_r;
    logic [CW-1:0] idx_r;
    logic          bit_s, idx_zero_s, add_sel_s;
    logic          dbl_start_s, add_start_s, done_s;

    function automatic logic scalar_bit(input logic [KW-1:0] kv, input logic [CW-1:0] i);
        logic [KW-1:0] sh;
        sh = kv >> i;
        return sh[0];
    endfunction

    function automatic ecc_point_t mk_point(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input logic inf);
        ecc_point_t p;
        p.x   = ECC_N'(x);
        p.y   = ECC_N'(y);
        p.inf = inf;
        return p;
    endfunction

    assign bit_s      = scalar_bit(k_r, idx_r);
    assign idx_zero_s = (idx_r == {CW{1'b0}});
    assign add_sel_s  = DUMMY_ADD | bit_s;

    assign dbl_x  = acc_r.x[N-1:0];
    assign dbl_y  = acc_r.y[N-1:0];
    assign add_x1 = acc_r.x[N-1:0];
    assign add_y1 = acc_r.y[N-1:0];
    assign add_x2 = px_r;
    assign add_y2 = py_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:     if (start) state_s = ST_SCAN; else state_s = ST_IDLE;
            ST_SCAN:     if (bit_s || idx_zero_s) state_s = idx_zero_s ? ST_FIN : ST_DBL_REQ;
                         else state_s = ST_SCAN;
            ST_DBL_REQ:  if (acc_r.inf) state_s = add_sel_s ? ST_ADD_REQ : ST_NEXT;
                         else state_s = ST_DBL_WAIT;
            ST_DBL_WAIT: if (dbl_done) state_s = add_sel_s ? ST_ADD_REQ : ST_NEXT;
                         else state_s = ST_DBL_WAIT;
            ST_ADD_REQ:  if (acc_r.inf) state_s = ST_NEXT; else state_s = ST_ADD_WAIT;
            ST_ADD_WAIT: if (add_done) state_s = ST_NEXT; else state_s = ST_ADD_WAIT;
            ST_NEXT:     if (idx_zero_s) state_s = ST_FIN; else state_s = ST_DBL_REQ;
            ST_FIN:      state_s = ST_IDLE;
            default:     state_s = ST_IDLE;
        endcase
    end

    // Output decode; an infinite accumulator short-circuits the unit call
    always_comb begin
        dbl_start_s = 1'b0;
        add_start_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_DBL_REQ: dbl_start_s = ~acc_r.inf;
            ST_ADD_REQ: add_start_s = ~acc_r.inf;
            ST_FIN:     done_s      = 1'b1;
            default:    done_s      = 1'b0;
        endcase
    end

    // Registered handshake pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            dbl_start <= 1'b0;
            add_start <= 1'b0;
            done      <= 1'b0;
        end else begin
            dbl_start <= dbl_start_s;
            add_start <= add_start_s;
            done      <= done_s;
        end
    end

    // Operand latch, bit index, accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            k_r   <= {KW{1'b0}};
            px_r  <= {N{1'b0}};
            py_r  <= {N{1'b0}};
            idx_r <= {CW{1'b0}};
            acc_r <= INF_POINT;
            busy  <= 1'b0;
            rx    <= {N{1'b0}};
            ry    <= {N{1'b0}};
            r_inf <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: if (start) begin
                    k_r   <= k;
                    px_r  <= px;
                    py_r  <= py;
                    idx_r <= CW'(KW - 1);
                    acc_r <= INF_POINT;
                    busy  <= 1'b1;
                end
                ST_SCAN: begin
                    if (bit_s) acc_r <= mk_point(px_r, py_r, 1'b0);
                    if (!idx_zero_s) idx_r <= idx_r - {{(CW-1){1'b0}}, 1'b1};
                end
                ST_DBL_WAIT: if (dbl_done) acc_r <= mk_point(dbl_x3, dbl_y3, dbl_inf);
                ST_ADD_REQ:  if (acc_r.inf && bit_s) acc_r <= mk_point(px_r, py_r, 1'b0);
                ST_ADD_WAIT: if (add_done && bit_s) acc_r <= mk_point(add_x3, add_y3, add_inf);
                ST_NEXT:     if (!idx_zero_s) idx_r <= idx_r - {{(CW-1){1'b0}}, 1'b1};
                ST_FIN: begin
                    rx    <= acc_r.x[N-1:0];
                    ry    <= acc_r.y[N-1:0];
                    r_inf <= acc_r.inf;
                    busy  <= 1'b0;
                end
                default: busy <= busy;
            endcase
        end
    end

endmodule

// File: doc/ecc_scalar_mult_ctrl.md
Name: ecc_scalar_mult_ctrl

Overview:
Sequencer for left-to-right double-and-add scalar multiplication R = k·P over a prime-field curve. It owns the accumulator point and the scalar bit scan. It drives one external point-doubling unit and one point-addition unit through start/done handshakes. It sits between the top-level ECC engine interface and the two point-arithmetic datapaths; it does no field arithmetic itself.

Parameters:
N, 231, field element width (x, y coordinates)
KW, 231, scalar width
CW, 8, bit-index counter width; must satisfy 2^CW > KW

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
k  in  KW  scalar; latched on accepted start
px  in  N  base point x; latched on accepted start
py  in  N  base point y; latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when result valid
rx  out  N  result x; held until next accepted start
ry  out  N  result y; held until next accepted start
r_inf  out  1  result is point at infinity
dbl_start  out  1  one-cycle pulse launching doubling
dbl_x  out  N  doubling operand x (accumulator)
dbl_y  out  N  doubling operand y (accumulator)
dbl_done  in  1  doubling result valid (pulse)
dbl_x3  in  N  doubling result x
dbl_y3  in  N  doubling result y
dbl_inf  in  1  doubling result is infinity
add_start  out  1  one-cycle pulse launching addition
add_x1  out  N  addition operand 1 x (accumulator)
add_y1  out  N  addition operand 1 y (accumulator)
add_x2  out  N  addition operand 2 x (latched P)
add_y2  out  N  addition operand 2 y (latched P)
add_done  in  1  addition result valid (pulse)
add_x3  in  N  addition result x
add_y3  in  N  addition result y
add_inf  in  1  addition result is infinity

Behaviour:
- Reset: FSM to IDLE; busy=0, done=0, dbl_start=0, add_start=0, rx=ry=0, r_inf=1, accumulator = infinity. Reset mid-operation aborts immediately; late dbl_done/add_done pulses are ignored in IDLE.
- States: IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, FIN.
- IDLE: on start=1, latch k/px/py, set idx=KW-1, set acc=inf, busy=1, go to SCAN. start while busy is ignored.
- SCAN: one bit per cycle. While k[idx]=0 and idx>0, decrement idx. If k==0, go to FIN with r_inf=1.
- At the first set bit, acc=P (no unit call). Then:
  - if idx==0, go to FIN;
  - otherwise decrement idx and go to DBL_REQ.
- DBL_REQ: if acc is infinity, acc stays infinity and FSM goes to the add decision (no unit call). Otherwise pulse dbl_start for exactly 1 cycle with operands stable and go to DBL_WAIT.
- DBL_WAIT: operands held stable. On dbl_done, acc = (dbl_x3, dbl_y3, dbl_inf).
- Add decision: if k[idx]=1, go to ADD_REQ; otherwise go to NEXT.
- ADD_REQ: if acc is infinity, acc=P (no unit call) and go to NEXT. Otherwise pulse add_start and go to ADD_WAIT.
- ADD_WAIT: operands held stable. On add_done, acc = add result; go to NEXT.
- NEXT: if idx==0, go to FIN; otherwise decrement idx and go to DBL_REQ.
- FIN: rx/ry/r_inf <= acc; done=1 for one cycle; busy=0; return to IDLE.
- Done inputs arriving outside their WAIT state are ignored. Units are never started concurrently.
- Latency:
  - 2 (start→SCAN) + bits scanned + per remaining bit (2 + Tdbl) + per set bit (2 + Tadd) + 1.
  - k=1 gives done 3+KW-1 cycles after start, with no unit starts.

Optional Feature:
ECC_DUMMY_ADD_EN
- Defined: an addition is issued for every bit after the leading one, with an identical handshake. The result is committed only when k[idx]=1 and discarded otherwise. Per-bit timing becomes independent of the bit value (side-channel hardening).
- Undefined: additions occur only for set bits, as above.

Decomposition:
- Package ecc_ctrl_pkg: FSM state enum, a point struct {x, y, inf} parameterised by N, the INF_POINT constant.
- No sub-module needed; a small scalar-scan helper is kept inline.

Test Plan:
Bench uses N=KW=8, curve y²=x³+2x+2 mod 17, P=(5,1), and stub units with 4-cycle latency returning table values.
- k=0 → done with r_inf=1; dbl_start/add_start never pulse.
- k=1 → rx=5, ry=1, r_inf=0; no unit starts; done exactly 10 cycles after start.
- k=5 → sequence dbl, dbl, add; rx=9, ry=16; exactly 2 dbl_start and 1 add_start pulses.
- k=19 → r_inf=1 from the final add_inf; start pulsed during busy is ignored (single done).
- Reset asserted in DBL_WAIT of k=5 → next cycle busy=0, r_inf=1; a late dbl_done is ignored; a new start with k=2 gives rx=6, ry=3.
- With ECC_DUMMY_ADD_EN and k=4 → 2 add_start pulses issued; result still (3,1).
